spi_slave_apb_seq: RTL and testbench
====================================

// Module: spi_slave_apb_seq
// PURPOSE
// - Sequences synchronised SPI-slave commands (cs/address/valid/rd_wr already in sys_clk domain) into APB master transfers.
// - Handles word bursts: write data pulled from RX word stream, read data pushed to TX word stream, address auto-increments.
// - Sits between the SPI->sys_clk synchroniser/data FIFOs and the SoC APB interconnect.
// PARAMETERS
// - ADDR_WIDTH  32  width of address_sync / paddr
// - DATA_WIDTH  32  width of APB data and RX/TX words
// - ADDR_INC    4   byte increment applied to paddr after each completed word
// PORTS
// - sys_clk             in   1           single clock, all logic posedge
// - rstn                in   1           asynchronous active-low reset
// - cs_sync             in   1           synchronised chip select, active low (1 = deselected)
// - address_sync        in   ADDR_WIDTH  command start address, valid with address_valid_sync
// - address_valid_sync  in   1           1-cycle pulse: new command
// - rd_wr_sync          in   1           command type: 1 = read, 0 = write
// - rx_data             in   DATA_WIDTH  write word from SPI RX path
// - rx_valid            in   1           rx_data available
// - rx_ready            out  1           1-cycle pulse: rx_data consumed
// - tx_data             out  DATA_WIDTH  read word to SPI TX path
// - tx_valid            out  1           tx_data valid, held until tx_ready
// - tx_ready            in   1           TX path accepts tx_data
// - paddr               out  ADDR_WIDTH  APB address
// - pwdata              out  DATA_WIDTH  APB write data
// - pwrite              out  1           APB direction
// - psel / penable      out  1 / 1       APB select / enable
// - prdata              in   DATA_WIDTH  APB read data
// - pready / pslverr    in   1 / 1       APB ready / slave error
// - busy                out  1           1 whenever state != IDLE
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, address register 0.
// - States: IDLE, WR_WAIT, SETUP, ACCESS, RD_PUSH.
// - IDLE: address_valid_sync=1 and cs_sync=0 -> addr<=address_sync, pwrite<=~rd_wr_sync; write -> WR_WAIT, read -> SETUP. Pulse with cs_sync=1 ignored.
// - WR_WAIT: cs_sync=1 -> IDLE (priority over rx_valid, rx_ready stays 0); else rx_valid=1 -> rx_ready=1 that cycle, pwdata<=rx_data, -> SETUP.
// - SETUP: psel=1, penable=0, one cycle, -> ACCESS. ACCESS: psel=1, penable=1, held until pready=1.
// - On ACCESS with pready=1: psel/penable drop next cycle; write -> addr+=ADDR_INC, -> WR_WAIT (IDLE if cs_sync=1);
//   read -> tx_data<=prdata, tx_valid<=1, -> RD_PUSH (IDLE, data discarded, if cs_sync=1).
// - RD_PUSH: tx_ready=1 -> tx_valid=0, addr+=ADDR_INC, -> SETUP (prefetch next word); cs_sync=1 -> tx_valid=0, -> IDLE (cs wins over tx_ready).
// - Latency: address pulse -> psel=1 is 1 cycle (read); rx_valid -> psel=1 is 1 cycle (write); min 3 cycles per APB word incl. hand-back.
// - cs_sync=1 during SETUP/ACCESS never aborts APB; transfer completes, then IDLE.
// - address_valid_sync while busy: ignored. Address wraps modulo 2^ADDR_WIDTH.
// - paddr, pwrite, pwdata stable from SETUP through ACCESS completion.
// - pslverr does not alter sequencing (word treated as done).
// CONFIGURATION
// - SPI_APB_SEQ_ERR_EN defined: adds outputs err_flag (1) and err_cnt (8).
//   err_flag sets on ACCESS&&pready&&pslverr and clears on next accepted command.
//   err_cnt increments per error and saturates at 255. Both reset to 0.
// - Undefined: ports absent, pslverr unused.
// TESTING
// - Single write: pulse addr=0x1000 rd_wr=0, rx word 0xDEADBEEF -> one APB write paddr=0x1000 pwdata=0xDEADBEEF, rx_ready 1 cycle.
// - Write burst 3 words at 0x2000, pready wait 2 cycles each -> paddr 0x2000/0x2004/0x2008, penable held until pready.
// - Read burst at 0x3000, prdata 0x11/0x22, tx_ready delayed 4 cycles -> tx_data 0x11 held with tx_valid; next read at 0x3004 only after tx_ready.
// - cs_sync=1 mid-ACCESS (read) -> access completes, tx_valid stays 0, busy=0 next cycle; later cmd at 0x4000 works.
// - Wrap: write at 0xFFFFFFFC, 2 words -> second paddr=0x00000000.
// - ERR_EN: pslverr on 2nd of 3 writes -> err_flag=1, err_cnt=1; new command clears err_flag, err_cnt stays 1.
// - Reset asserted mid-ACCESS -> psel/penable/tx_valid/busy = 0 immediately.

Source files
------------

// File: rtl/spi_slave_apb_seq.sv
// ============================================================================
// Module   : spi_slave_apb_seq
// Brief    : Turns synchronised SPI-slave commands into APB master word bursts.
//            Optional error tracking enabled by defining SPI_APB_SEQ_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_slave_apb_seq #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_INC   = 4
) (
    input  logic                  sys_clk,
    input  logic                  rstn,
    input  logic                  cs_sync,
    input  logic [ADDR_WIDTH-1:0] address_sync,
    input  logic                  address_valid_sync,
    input  logic                  rd_wr_sync,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pwrite,
    output logic                  psel,
    output logic                  penable,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr,
    output logic                  busy
`ifdef SPI_APB_SEQ_ERR_EN
    ,
    output logic                  err_flag,
    output logic [7:0]            err_cnt
`endif
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_WAIT = 3'd1;
    localparam logic [2:0] S_SETUP   = 3'd2;
    localparam logic [2:0] S_ACCESS  = 3'd3;
    localparam logic [2:0] S_RD_PUSH = 3'd4;

    logic [2:0]            r_state;
    logic [2:0]            w_next_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] w_addr_next;
    logic                  r_pwrite;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_tx_valid;
    logic                  w_cmd_accept;
    logic                  w_rx_take;
    logic                  w_apb_done;

    assign w_cmd_accept = (r_state == S_IDLE) && address_valid_sync && !cs_sync;
    assign w_rx_take    = (r_state == S_WR_WAIT) && !cs_sync && rx_valid;
    assign w_apb_done   = (r_state == S_ACCESS) && pready;
    assign w_addr_next  = r_addr + ADDR_WIDTH'(ADDR_INC);

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // cs_sync never interrupts SETUP/ACCESS; it is only honoured at word boundaries
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_cmd_accept) begin
                    w_next_state = rd_wr_sync ? S_SETUP : S_WR_WAIT;
                end
            end
            S_WR_WAIT: begin
                if (cs_sync) begin
                    w_next_state = S_IDLE;
                end else if (rx_valid) begin
                    w_next_state = S_SETUP;
                end
            end
            S_SETUP: begin
                w_next_state = S_ACCESS;
            end
            S_ACCESS: begin
                if (pready) begin
                    if (cs_sync) begin
                        w_next_state = S_IDLE;
                    end else begin
                        w_next_state = r_pwrite ? S_WR_WAIT : S_RD_PUSH;
                    end
                end
            end
            S_RD_PUSH: begin
                if (cs_sync) begin
                    w_next_state = S_IDLE;
                end else if (tx_ready) begin
                    w_next_state = S_SETUP;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_comb begin
        psel     = (r_state == S_SETUP) || (r_state == S_ACCESS);
        penable  = (r_state == S_ACCESS);
        rx_ready = w_rx_take;
        busy     = (r_state != S_IDLE);
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            r_addr     <= '0;
            r_pwrite   <= 1'b0;
            r_pwdata   <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
        end else begin
            if (w_cmd_accept) begin
                r_addr   <= address_sync;
                r_pwrite <= ~rd_wr_sync;
            end
            if (w_rx_take) begin
                r_pwdata <= rx_data;
            end
            if (w_apb_done) begin
                if (r_pwrite) begin
                    r_addr <= w_addr_next;
                end else if (!cs_sync) begin
                    r_tx_data  <= prdata;
                    r_tx_valid <= 1'b1;
                end
            end
            // Read address advances only once the TX path has taken the word
            if (r_state == S_RD_PUSH) begin
                if (cs_sync) begin
                    r_tx_valid <= 1'b0;
                end else if (tx_ready) begin
                    r_tx_valid <= 1'b0;
                    r_addr     <= w_addr_next;
                end
            end
        end
    end

    assign paddr    = r_addr;
    assign pwrite   = r_pwrite;
    assign pwdata   = r_pwdata;
    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;

`ifdef SPI_APB_SEQ_ERR_EN
    logic       r_err_flag;
    logic [7:0] r_err_cnt;

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            r_err_flag <= 1'b0;
            r_err_cnt  <= 8'd0;
        end else begin
            if (w_cmd_accept) begin
                r_err_flag <= 1'b0;
            end else if (w_apb_done && pslverr) begin
                r_err_flag <= 1'b1;
            end
            if (w_apb_done && pslverr && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign err_flag = r_err_flag;
    assign err_cnt  = r_err_cnt;
`else
    logic w_unused_pslverr;
    assign w_unused_pslverr = pslverr;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_apb_seq.sv
// ============================================================================
// Module   : tb_spi_slave_apb_seq
// Brief    : Directed self-checking bench for spi_slave_apb_seq with a small
//            APB slave model that logs completed transfers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_slave_apb_seq;

    logic        sys_clk = 1'b0;
    logic        rstn;
    logic        cs_sync;
    logic [31:0] address_sync;
    logic        address_valid_sync;
    logic        rd_wr_sync;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        busy;
`ifdef SPI_APB_SEQ_ERR_EN
    logic        err_flag;
    logic [7:0]  err_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    spi_slave_apb_seq #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ADDR_INC(4)) dut (
        .sys_clk(sys_clk), .rstn(rstn), .cs_sync(cs_sync),
        .address_sync(address_sync), .address_valid_sync(address_valid_sync),
        .rd_wr_sync(rd_wr_sync), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
        .psel(psel), .penable(penable), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .busy(busy)
`ifdef SPI_APB_SEQ_ERR_EN
        , .err_flag(err_flag), .err_cnt(err_cnt)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    // APB slave model: configurable wait states, transfer log, read data table
    int          wait_cycles = 0;
    int          acc_cnt     = 0;
    int          n_txn       = 0;
    int          n_rd        = 0;
    int          err_idx     = -1;
    int          rx_ready_cyc = 0;
    int          tx_valid_cyc = 0;
    logic [31:0] rd_word [0:3];
    logic [31:0] log_addr [0:63];
    logic [31:0] log_data [0:63];
    logic        log_wr   [0:63];
    int          log_wait [0:63];

    assign pready  = psel && penable && (acc_cnt >= wait_cycles);
    assign prdata  = rd_word[n_rd % 4];
    assign pslverr = (n_txn == err_idx);

    always @(posedge sys_clk) begin
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
        if (psel && penable && pready) begin
            log_addr[n_txn % 64] <= paddr;
            log_data[n_txn % 64] <= pwrite ? pwdata : prdata;
            log_wr[n_txn % 64]   <= pwrite;
            log_wait[n_txn % 64] <= acc_cnt;
            n_txn <= n_txn + 1;
            if (!pwrite) n_rd <= n_rd + 1;
        end
        if (rx_ready) rx_ready_cyc <= rx_ready_cyc + 1;
        if (tx_valid) tx_valid_cyc <= tx_valid_cyc + 1;
    end

    task automatic drive_cmd(input logic [31:0] a, input logic rd);
        @(negedge sys_clk);
        address_sync = a;
        rd_wr_sync = rd;
        address_valid_sync = 1'b1;
        @(negedge sys_clk);
        address_valid_sync = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, output bit ok,
                             output logic sel_after, output logic en_after);
        ok = 1'b0;
        sel_after = 1'b0;
        en_after = 1'b0;
        rx_data = d;
        rx_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (rx_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge sys_clk);
        end
        if (ok) begin
            @(negedge sys_clk);
            sel_after = psel;
            en_after = penable;
        end
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge sys_clk);
        end
    endtask

    task automatic wait_txv(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (tx_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge sys_clk);
        end
    endtask

    task automatic wait_access(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (psel && penable) begin
                ok = 1'b1;
                break;
            end
            @(negedge sys_clk);
        end
    endtask

    task automatic test_reset;
        @(negedge sys_clk);
        n_checks++;
        if ({psel, penable, tx_valid, busy, rx_ready, pwrite} !== 6'b0) $display("FAIL reset_ctrl got=%b exp=000000", {psel, penable, tx_valid, busy, rx_ready, pwrite});
        else n_pass++;
        n_checks++;
        if ({paddr, pwdata, tx_data} !== 96'h0) $display("FAIL reset_data paddr=%h pwdata=%h tx_data=%h exp=0", paddr, pwdata, tx_data);
        else n_pass++;
        rstn = 1'b1;
        cs_sync = 1'b0;
    endtask

    task automatic test_single_write;
        bit ok;
        logic s, e;
        int base = n_txn;
        int rxc = rx_ready_cyc;
        wait_cycles = 0;
        drive_cmd(32'h1000, 1'b0);
        n_checks++;
        if (busy !== 1'b1 || psel !== 1'b0) $display("FAIL sw_wrwait busy=%b psel=%b exp busy=1 psel=0", busy, psel);
        else n_pass++;
        send_word(32'hDEADBEEF, ok, s, e);
        n_checks++;
        if (!ok || s !== 1'b1 || e !== 1'b0) $display("FAIL sw_latency ok=%0d psel=%b penable=%b exp 1/1/0", ok, s, e);
        else n_pass++;
        cs_sync = 1'b1;
        wait_idle(ok);
        n_checks++;
        if (!ok || n_txn - base != 1 || log_addr[base % 64] !== 32'h1000 || log_data[base % 64] !== 32'hDEADBEEF || log_wr[base % 64] !== 1'b1)
            $display("FAIL sw_apb ok=%0d n=%0d addr=%h data=%h wr=%b exp n=1 addr=1000 data=deadbeef wr=1", ok, n_txn - base, log_addr[base % 64], log_data[base % 64], log_wr[base % 64]);
        else n_pass++;
        n_checks++;
        if (rx_ready_cyc - rxc != 1) $display("FAIL sw_rx_ready_pulse got=%0d exp=1", rx_ready_cyc - rxc);
        else n_pass++;
        cs_sync = 1'b0;
    endtask

    task automatic test_write_burst;
        bit ok;
        logic s, e;
        int base = n_txn;
        int bad = 0;
        wait_cycles = 2;
        drive_cmd(32'h2000, 1'b0);
        for (int i = 0; i < 3; i++) send_word(32'hA000_0000 + i, ok, s, e);
        cs_sync = 1'b1;
        wait_idle(ok);
        for (int i = 0; i < 3; i++)
            if (log_addr[(base + i) % 64] !== 32'h2000 + 4 * i || log_data[(base + i) % 64] !== 32'hA000_0000 + i || log_wait[(base + i) % 64] != 2) bad++;
        n_checks++;
        if (!ok || n_txn - base != 3 || bad != 0) $display("FAIL wb_burst ok=%0d n=%0d bad_words=%0d exp n=3 bad=0", ok, n_txn - base, bad);
        else n_pass++;
        n_checks++;
        if (log_addr[(base + 2) % 64] !== 32'h2008) $display("FAIL wb_third_addr got=%h exp=00002008", log_addr[(base + 2) % 64]);
        else n_pass++;
        cs_sync = 1'b0;
        wait_cycles = 0;
    endtask

    task automatic test_read_burst;
        bit ok;
        int base = n_txn;
        int bad = 0;
        rd_word[n_rd % 4] = 32'h11;
        rd_word[(n_rd + 1) % 4] = 32'h22;
        tx_ready = 1'b0;
        drive_cmd(32'h3000, 1'b1);
        n_checks++;
        if (psel !== 1'b1 || penable !== 1'b0 || paddr !== 32'h3000) $display("FAIL rb_latency psel=%b penable=%b paddr=%h exp 1/0/3000", psel, penable, paddr);
        else n_pass++;
        wait_txv(ok);
        n_checks++;
        if (!ok || tx_data !== 32'h11) $display("FAIL rb_first ok=%0d tx_data=%h exp=00000011", ok, tx_data);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            if (tx_valid !== 1'b1 || tx_data !== 32'h11 || psel !== 1'b0) bad++;
            @(negedge sys_clk);
        end
        n_checks++;
        if (bad != 0) $display("FAIL rb_hold bad_cycles=%0d exp=0", bad);
        else n_pass++;
        tx_ready = 1'b1;
        @(negedge sys_clk);
        tx_ready = 1'b0;
        n_checks++;
        if (tx_valid !== 1'b0 || psel !== 1'b1 || paddr !== 32'h3004) $display("FAIL rb_prefetch tx_valid=%b psel=%b paddr=%h exp 0/1/3004", tx_valid, psel, paddr);
        else n_pass++;
        wait_txv(ok);
        n_checks++;
        if (!ok || tx_data !== 32'h22) $display("FAIL rb_second ok=%0d tx_data=%h exp=00000022", ok, tx_data);
        else n_pass++;
        cs_sync = 1'b1;
        @(negedge sys_clk);
        n_checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || n_txn - base != 2) $display("FAIL rb_cs_end tx_valid=%b busy=%b n=%0d exp 0/0/2", tx_valid, busy, n_txn - base);
        else n_pass++;
        cs_sync = 1'b0;
    endtask

    task automatic test_cs_abort;
        bit ok;
        bit seen = 1'b0;
        logic s, e;
        int base = n_txn;
        int txc = tx_valid_cyc;
        wait_cycles = 3;
        drive_cmd(32'h3100, 1'b1);
        wait_access(ok);
        cs_sync = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (pready) begin
                seen = 1'b1;
                break;
            end
            @(negedge sys_clk);
        end
        @(negedge sys_clk);
        n_checks++;
        if (!seen || busy !== 1'b0 || tx_valid_cyc != txc || n_txn - base != 1 || log_addr[base % 64] !== 32'h3100)
            $display("FAIL cs_abort seen=%0d busy=%b txv_cycles=%0d n=%0d addr=%h exp 1/0/0/1/3100", seen, busy, tx_valid_cyc - txc, n_txn - base, log_addr[base % 64]);
        else n_pass++;
        cs_sync = 1'b0;
        wait_cycles = 0;
        drive_cmd(32'h4000, 1'b0);
        send_word(32'h55, ok, s, e);
        cs_sync = 1'b1;
        wait_idle(ok);
        n_checks++;
        if (!ok || log_addr[(base + 1) % 64] !== 32'h4000 || log_data[(base + 1) % 64] !== 32'h55)
            $display("FAIL cs_next_cmd ok=%0d addr=%h data=%h exp 4000/55", ok, log_addr[(base + 1) % 64], log_data[(base + 1) % 64]);
        else n_pass++;
        cs_sync = 1'b0;
    endtask

    task automatic test_wrap;
        bit ok;
        logic s, e;
        int base = n_txn;
        drive_cmd(32'hFFFF_FFFC, 1'b0);
        send_word(32'h1, ok, s, e);
        send_word(32'h2, ok, s, e);
        cs_sync = 1'b1;
        wait_idle(ok);
        n_checks++;
        if (!ok || log_addr[base % 64] !== 32'hFFFF_FFFC || log_addr[(base + 1) % 64] !== 32'h0)
            $display("FAIL wrap ok=%0d a0=%h a1=%h exp fffffffc/00000000", ok, log_addr[base % 64], log_addr[(base + 1) % 64]);
        else n_pass++;
        cs_sync = 1'b0;
    endtask

    task automatic test_ignored;
        bit ok;
        logic s, e;
        int base = n_txn;
        cs_sync = 1'b1;
        drive_cmd(32'h5500, 1'b1);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL ign_cs_high busy=%b exp=0", busy);
        else n_pass++;
        cs_sync = 1'b0;
        drive_cmd(32'h5000, 1'b0);
        drive_cmd(32'h6000, 1'b1);
        n_checks++;
        if (busy !== 1'b1 || psel !== 1'b0 || paddr !== 32'h5000 || pwrite !== 1'b1)
            $display("FAIL ign_busy busy=%b psel=%b paddr=%h pwrite=%b exp 1/0/5000/1", busy, psel, paddr, pwrite);
        else n_pass++;
        send_word(32'h77, ok, s, e);
        cs_sync = 1'b1;
        wait_idle(ok);
        n_checks++;
        if (!ok || n_txn - base != 1 || log_addr[base % 64] !== 32'h5000 || log_wr[base % 64] !== 1'b1)
            $display("FAIL ign_txn ok=%0d n=%0d addr=%h wr=%b exp 1/5000/1", ok, n_txn - base, log_addr[base % 64], log_wr[base % 64]);
        else n_pass++;
        cs_sync = 1'b0;
    endtask

`ifdef SPI_APB_SEQ_ERR_EN
    task automatic test_err;
        bit ok;
        logic s, e;
        err_idx = n_txn + 1;
        drive_cmd(32'h7000, 1'b0);
        for (int i = 0; i < 3; i++) send_word(32'hE0 + i, ok, s, e);
        cs_sync = 1'b1;
        wait_idle(ok);
        err_idx = -1;
        n_checks++;
        if (!ok || err_flag !== 1'b1 || err_cnt !== 8'd1) $display("FAIL err_set ok=%0d flag=%b cnt=%0d exp 1/1", ok, err_flag, err_cnt);
        else n_pass++;
        cs_sync = 1'b0;
        drive_cmd(32'h7100, 1'b0);
        n_checks++;
        if (err_flag !== 1'b0 || err_cnt !== 8'd1) $display("FAIL err_clear flag=%b cnt=%0d exp 0/1", err_flag, err_cnt);
        else n_pass++;
        cs_sync = 1'b1;
        wait_idle(ok);
        cs_sync = 1'b0;
    endtask
`endif

    task automatic test_reset_mid_access;
        bit ok;
        wait_cycles = 5;
        drive_cmd(32'h8000, 1'b1);
        wait_access(ok);
        rstn = 1'b0;
        #1;
        n_checks++;
        if (!ok || {psel, penable, tx_valid, busy} !== 4'b0) $display("FAIL reset_mid ok=%0d psel/pen/txv/busy=%b exp=0000", ok, {psel, penable, tx_valid, busy});
        else n_pass++;
        @(negedge sys_clk);
        rstn = 1'b1;
        wait_cycles = 0;
    endtask

    initial begin
        rstn = 1'b0;
        cs_sync = 1'b1;
        address_sync = '0;
        address_valid_sync = 1'b0;
        rd_wr_sync = 1'b0;
        rx_data = '0;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) rd_word[i] = 32'h0;
        test_reset();
        test_single_write();
        test_write_burst();
        test_read_burst();
        test_cs_abort();
        test_wrap();
        test_ignored();
`ifdef SPI_APB_SEQ_ERR_EN
        test_err();
`endif
        test_reset_mid_access();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
